// File: rtl/parity_pkg.sv
// Shared constants for the stream parity checker: FSM state codes and
// parity-mode encodings.
package parity_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/stream_parity_checker_word_parity.sv
// word_parity: combinational WIDTH-bit parity reduction. Returns the data
// parity, the parity bit the sender should have attached for the selected
// mode, and a flag when the transmitted bit disagrees.
module word_parity
  import parity_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             mode,
  input  logic             par,
  output logic             data_par,
  output logic             expected,
  output logic             mismatch
);

  assign data_par = ^data;
  assign expected = (mode == PAR_ODD) ? ~data_par : data_par;
  assign mismatch = par ^ expected;

endmodule

// File: rtl/stream_parity_checker.sv
// stream_parity_checker: checks per-word parity on a framed valid/ready
// stream and reports frame parity, word count and error count per frame.
// Optional macro STICKY_ERR_EN adds err_sticky, set on any mismatch and
// cleared only by rst.
module stream_parity_checker
  import parity_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_par,
  input  logic             in_last,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_frame_par,
  output logic [CNT_W-1:0] out_word_cnt,
  output logic [CNT_W-1:0] out_err_cnt,
  output logic             out_frame_ok
`ifdef STICKY_ERR_EN
  ,
  output logic             err_sticky
`endif
);

  logic [1:0]       state;
  logic             mode_lat;
  logic             par_acc;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] err_cnt;

  logic             accept;
  logic             first;
  logic             mode_eff;
  logic             data_par;
  logic             expected;
  logic             mismatch;
  logic             par_nx;
  logic [CNT_W-1:0] wc_nx;
  logic [CNT_W-1:0] ec_nx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic inc);
    return (inc && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  assign in_ready = (state != ST_HOLD);
  assign accept   = in_valid && in_ready;
  assign first    = (state == ST_IDLE);
  // Mode is sampled live on the first word and frozen for the rest of the frame.
  assign mode_eff = first ? mode : mode_lat;

  word_parity #(.WIDTH(WIDTH)) u_word_parity (
    .data     (in_data),
    .mode     (mode_eff),
    .par      (in_par),
    .data_par (data_par),
    .expected (expected),
    .mismatch (mismatch)
  );

  // Next accumulator values including the word being accepted this cycle.
  always_comb begin
    par_nx = par_acc ^ data_par;
    wc_nx  = sat_inc(word_cnt, 1'b1);
    ec_nx  = sat_inc(err_cnt, mismatch);
    if (first) begin
      par_nx = data_par;
      wc_nx  = CNT_W'(1);
      ec_nx  = CNT_W'(mismatch);
    end
  end

  // Frame FSM, accumulators and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      mode_lat      <= PAR_EVEN;
      par_acc       <= 1'b0;
      word_cnt      <= '0;
      err_cnt       <= '0;
      out_valid     <= 1'b0;
      out_frame_par <= 1'b0;
      out_word_cnt  <= '0;
      out_err_cnt   <= '0;
      out_frame_ok  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (accept) begin
            if (first) mode_lat <= mode;
            par_acc  <= par_nx;
            word_cnt <= wc_nx;
            err_cnt  <= ec_nx;
            if (in_last) begin
              state         <= ST_HOLD;
              out_valid     <= 1'b1;
              out_frame_par <= par_nx;
              out_word_cnt  <= wc_nx;
              out_err_cnt   <= ec_nx;
              out_frame_ok  <= (ec_nx == '0);
            end else begin
              state <= ST_ACCUM;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef STICKY_ERR_EN
  // Cross-frame error flag; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       err_sticky <= 1'b0;
    else if (accept && mismatch)   err_sticky <= 1'b1;
  end
`endif

endmodule
